// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   - Default MMIO addresses and the halt magic word.
//   - owner_t: tag of the access granted in the previous cycle, used to
//     route the returning read word (or the MMIO read zero) to its port.
//   - sat_inc4: saturating 4-bit increment for the imem starvation counter.
package mem_arb_pkg;

  localparam logic [31:0] SIG_ADDR_DEF   = 32'hF000_0004;
  localparam logic [31:0] HALT_ADDR_DEF  = 32'hCAFE_CAFE;
  localparam logic [31:0] HALT_MAGIC_DEF = 32'hF000_0000;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2,
    OWN_MMIO = 2'd3
  } owner_t;

  // Increment val by one, never exceeding lim.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
    if (val >= lim) begin
      return lim;
    end else begin
      return val + 4'd1;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core ports, the arbiter and the backing memory.
//   slave  : the arbiter's view (takes requests and mem_rdata, drives
//            grants, read returns, memory strobes and MMIO results).
//   master : the surrounding core + memory view (the reverse directions).
// Core side : imem_req/addr/gnt/rvalid/rdata, dmem_req/we/addr/wdata/gnt/rvalid/rdata
// Memory    : mem_en, mem_we, mem_addr[MEM_AW-1:0], mem_wdata, mem_rdata
// MMIO      : sig_valid, sig_data, halt
interface mem_port_arbiter_if #(
  parameter int MEM_AW = 20
);

  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  logic              dmem_req;
  logic              dmem_we;
  logic [31:0]       dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              sig_valid;
  logic [31:0]       sig_data;
  logic              halt;

  modport slave (
    input  imem_req, imem_addr,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  mem_rdata,
    output imem_gnt, imem_rvalid, imem_rdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output sig_valid, sig_data, halt
  );

  modport master (
    output imem_req, imem_addr,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output mem_rdata,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  sig_valid, sig_data, halt
  );

endinterface

// File: rtl/mem_port_arbiter_mmio_decode.sv
// Combinational MMIO decode of the data-port address/data.
//   addr_i     : dmem byte address (full 32-bit compare)
//   wdata_i    : dmem write data
//   sig_hit_o  : address is the signature register
//   halt_hit_o : address is the halt register and data is the halt magic
//   mmio_hit_o : address is any MMIO register (access must not reach memory)
module mmio_decode
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] SIG_ADDR   = SIG_ADDR_DEF,
  parameter logic [31:0] HALT_ADDR  = HALT_ADDR_DEF,
  parameter logic [31:0] HALT_MAGIC = HALT_MAGIC_DEF
) (
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        sig_hit_o,
  output logic        halt_hit_o,
  output logic        mmio_hit_o
);

  logic sig_addr_s;
  logic halt_addr_s;

  assign sig_addr_s  = (addr_i == SIG_ADDR);
  assign halt_addr_s = (addr_i == HALT_ADDR);

  assign sig_hit_o  = sig_addr_s;
  // A halt-address access with any other data is still MMIO, it just does nothing.
  assign halt_hit_o = halt_addr_s && (wdata_i == HALT_MAGIC);
  assign mmio_hit_o = sig_addr_s || halt_addr_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous word memory between the instruction
// fetch port and the data port. dmem has priority; imem is forced through
// once it has been denied STARVE_MAX consecutive cycles. Signature and halt
// MMIO addresses on the data port are decoded here and never reach memory.
// Ports:
//   sysclk : clock, all state on the rising edge
//   rst_in : synchronous reset, active-high
//   bus    : mem_port_arbiter_if.slave (core ports, memory port, MMIO results)
// Grants and memory strobes are combinational; read data returns one cycle
// after the grant, steered by a registered owner tag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          MEM_AW     = 20,
  parameter int          STARVE_MAX = 4,
  parameter logic [31:0] SIG_ADDR   = SIG_ADDR_DEF,
  parameter logic [31:0] HALT_ADDR  = HALT_ADDR_DEF,
  parameter logic [31:0] HALT_MAGIC = HALT_MAGIC_DEF
) (
  input  logic               sysclk,
  input  logic               rst_in,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              sig_hit_s;
  logic              halt_hit_s;
  logic              mmio_hit_s;
  logic              arb_ok_s;
  logic              imem_force_s;
  logic              imem_gnt_s;
  logic              dmem_gnt_s;
  logic              dmem_acc_s;
  logic              imem_rvalid_s;
  logic              dmem_rvalid_s;
  logic [31:0]       imem_rdata_s;
  logic [31:0]       dmem_rdata_s;
  logic [MEM_AW-1:0] mem_addr_s;
  logic              unused_imem_addr_bits_s;

  logic [3:0]  starve_q, starve_d;
  owner_t      owner_q, owner_d;
  logic        halt_q, halt_d;
  logic        sig_valid_q, sig_valid_d;
  logic [31:0] sig_data_q, sig_data_d;
  logic [31:0] imem_hold_q, imem_hold_d;
  logic [31:0] dmem_hold_q, dmem_hold_d;

  mmio_decode #(
    .SIG_ADDR   (SIG_ADDR),
    .HALT_ADDR  (HALT_ADDR),
    .HALT_MAGIC (HALT_MAGIC)
  ) u_mmio_decode (
    .addr_i     (bus.dmem_addr),
    .wdata_i    (bus.dmem_wdata),
    .sig_hit_o  (sig_hit_s),
    .halt_hit_o (halt_hit_s),
    .mmio_hit_o (mmio_hit_s)
  );

  // Fetch addresses wrap inside the memory; the dropped bits are intentionally ignored.
  assign unused_imem_addr_bits_s = ^{bus.imem_addr[31:MEM_AW+2], bus.imem_addr[1:0]};

  // Grant is blocked in reset and once halted; a starved imem overrides dmem priority.
  assign arb_ok_s     = !rst_in && !halt_q;
  assign imem_force_s = bus.imem_req && (starve_q == STARVE_LIM);
  assign imem_gnt_s   = arb_ok_s && bus.imem_req && (imem_force_s || !bus.dmem_req);
  assign dmem_gnt_s   = arb_ok_s && bus.dmem_req && !imem_force_s;
  assign dmem_acc_s   = dmem_gnt_s && !mmio_hit_s;

  // Memory address mux: zero when nothing is accessing memory.
  always_comb begin
    mem_addr_s = {MEM_AW{1'b0}};
    if (imem_gnt_s) begin
      mem_addr_s = bus.imem_addr[MEM_AW+1:2];
    end else if (dmem_acc_s) begin
      mem_addr_s = bus.dmem_addr[MEM_AW+1:2];
    end else begin
      mem_addr_s = {MEM_AW{1'b0}};
    end
  end

  // Read-return steering from the owner tag; reset in this cycle kills the return.
  always_comb begin
    imem_rvalid_s = 1'b0;
    dmem_rvalid_s = 1'b0;
    case (owner_q)
      OWN_IMEM: imem_rvalid_s = !rst_in;
      OWN_DMEM: dmem_rvalid_s = !rst_in;
      OWN_MMIO: dmem_rvalid_s = !rst_in;
      default: begin
        imem_rvalid_s = 1'b0;
        dmem_rvalid_s = 1'b0;
      end
    endcase
    imem_rdata_s = imem_rvalid_s ? bus.mem_rdata : imem_hold_q;
    if (dmem_rvalid_s) begin
      dmem_rdata_s = (owner_q == OWN_MMIO) ? 32'h0000_0000 : bus.mem_rdata;
    end else begin
      dmem_rdata_s = dmem_hold_q;
    end
  end

  // Next-state for owner tag, starvation counter, halt latch, signature capture and read holds.
  always_comb begin
    owner_d     = OWN_NONE;
    starve_d    = 4'd0;
    halt_d      = halt_q;
    sig_valid_d = 1'b0;
    sig_data_d  = sig_data_q;
    imem_hold_d = imem_rdata_s;
    dmem_hold_d = dmem_rdata_s;

    if (imem_gnt_s) begin
      owner_d = OWN_IMEM;
    end else if (dmem_gnt_s && !bus.dmem_we) begin
      owner_d = mmio_hit_s ? OWN_MMIO : OWN_DMEM;
    end else begin
      owner_d = OWN_NONE;
    end

    if (bus.imem_req && !imem_gnt_s) begin
      starve_d = sat_inc4(starve_q, STARVE_LIM);
    end else begin
      starve_d = 4'd0;
    end

    if (dmem_gnt_s && bus.dmem_we && halt_hit_s) begin
      halt_d = 1'b1;
    end else begin
      halt_d = halt_q;
    end

    if (dmem_gnt_s && bus.dmem_we && sig_hit_s) begin
      sig_valid_d = 1'b1;
      sig_data_d  = bus.dmem_wdata;
    end else begin
      sig_valid_d = 1'b0;
      sig_data_d  = sig_data_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge sysclk) begin
    if (rst_in) begin
      owner_q     <= OWN_NONE;
      starve_q    <= 4'd0;
      halt_q      <= 1'b0;
      sig_valid_q <= 1'b0;
      sig_data_q  <= 32'h0000_0000;
      imem_hold_q <= 32'h0000_0000;
      dmem_hold_q <= 32'h0000_0000;
    end else begin
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      halt_q      <= halt_d;
      sig_valid_q <= sig_valid_d;
      sig_data_q  <= sig_data_d;
      imem_hold_q <= imem_hold_d;
      dmem_hold_q <= dmem_hold_d;
    end
  end

  assign bus.imem_gnt    = imem_gnt_s;
  assign bus.dmem_gnt    = dmem_gnt_s;
  assign bus.imem_rvalid = imem_rvalid_s;
  assign bus.dmem_rvalid = dmem_rvalid_s;
  assign bus.imem_rdata  = imem_rdata_s;
  assign bus.dmem_rdata  = dmem_rdata_s;
  assign bus.mem_en      = imem_gnt_s || dmem_acc_s;
  assign bus.mem_we      = dmem_acc_s && bus.dmem_we;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_wdata   = (dmem_acc_s && bus.dmem_we) ? bus.dmem_wdata : 32'h0000_0000;
  assign bus.sig_valid   = sig_valid_q;
  assign bus.sig_data    = sig_data_q;
  assign bus.halt        = halt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a cycle-level
// behavioural model (integer counters, a shadow memory array and a
// one-entry pending-return record).
module tb_mem_port_arbiter;

  localparam int          AW    = 8;
  localparam int          DEPTH = 256;
  localparam int          SMAX  = 4;
  localparam logic [31:0] SIG_A = 32'hF000_0004;
  localparam logic [31:0] HLT_A = 32'hCAFE_CAFE;
  localparam logic [31:0] MAGIC = 32'hF000_0000;

  logic sysclk = 1'b0;
  logic rst_in;

  mem_port_arbiter_if #(.MEM_AW(AW)) bus ();

  mem_port_arbiter #(
    .MEM_AW     (AW),
    .STARVE_MAX (SMAX),
    .SIG_ADDR   (SIG_A),
    .HALT_ADDR  (HLT_A),
    .HALT_MAGIC (MAGIC)
  ) dut (
    .sysclk (sysclk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [31:0] init_val(input int a);
    return 32'h1357_0000 ^ (32'(a) * 32'h0001_0203);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  // Backing memory: synchronous, one access per cycle, unwritten words read init_val.
  logic [31:0] mem [DEPTH];
  bit          wr  [DEPTH];
  always @(posedge sysclk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wr[bus.mem_addr]  <= 1'b1;
      end else begin
        bus.mem_rdata <= wr[bus.mem_addr] ? mem[bus.mem_addr] : init_val(int'(bus.mem_addr));
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus
  logic        s_rst, s_ireq, s_dreq, s_dwe;
  logic [31:0] s_iaddr, s_daddr, s_dwdata;
  logic        g_i, g_d;

  // Reference model
  int          m_starve;
  bit          m_halt;
  int          m_pend;           // 0 none, 1 imem return, 2 dmem return
  logic [31:0] m_pend_data;
  logic [31:0] m_last_i, m_last_d;
  bit          m_sig_pend;
  logic [31:0] m_sig_data;
  logic [31:0] ref_mem [DEPTH];

  // Observed at the last check point
  logic        o_ig, o_dg, o_men, o_sigv, o_halt, o_dval;
  logic [31:0] o_maddr, o_sigd, o_irdata;

  task automatic run_cycle();
    logic        e_ig, e_dg, mmio, e_men, e_we, e_iv, e_dv;
    int          idx;
    rst_in          = s_rst;
    bus.imem_req    = s_ireq;
    bus.imem_addr   = s_iaddr;
    bus.dmem_req    = s_dreq;
    bus.dmem_we     = s_dwe;
    bus.dmem_addr   = s_daddr;
    bus.dmem_wdata  = s_dwdata;
    @(negedge sysclk);
    e_ig = 1'b0;
    e_dg = 1'b0;
    if (!s_rst && !m_halt) begin
      if (s_ireq && (m_starve == SMAX || !s_dreq)) e_ig = 1'b1;
      else if (s_dreq) e_dg = 1'b1;
    end
    mmio  = (s_daddr == SIG_A) || (s_daddr == HLT_A);
    e_men = e_ig || (e_dg && !mmio);
    e_we  = e_dg && s_dwe && !mmio;
    idx   = e_ig ? widx(s_iaddr) : widx(s_daddr);
    e_iv  = !s_rst && (m_pend == 1);
    e_dv  = !s_rst && (m_pend == 2);
    check_val("imem_gnt", bus.imem_gnt, e_ig);
    check_val("dmem_gnt", bus.dmem_gnt, e_dg);
    check_val("mem_en", bus.mem_en, e_men);
    check_val("mem_we", bus.mem_we, e_we);
    if (e_men) check_val("mem_addr", 32'(bus.mem_addr), 32'(idx));
    if (e_we) check_val("mem_wdata", bus.mem_wdata, s_dwdata);
    check_val("imem_rvalid", bus.imem_rvalid, e_iv);
    check_val("dmem_rvalid", bus.dmem_rvalid, e_dv);
    check_val("imem_rdata", bus.imem_rdata, e_iv ? m_pend_data : m_last_i);
    check_val("dmem_rdata", bus.dmem_rdata, e_dv ? m_pend_data : m_last_d);
    check_val("sig_valid", bus.sig_valid, m_sig_pend);
    if (m_sig_pend) check_val("sig_data", bus.sig_data, m_sig_data);
    check_val("halt", bus.halt, m_halt);
    o_ig = bus.imem_gnt; o_dg = bus.dmem_gnt; o_men = bus.mem_en;
    o_maddr = 32'(bus.mem_addr); o_sigv = bus.sig_valid; o_sigd = bus.sig_data;
    o_halt = bus.halt; o_dval = bus.dmem_rvalid; o_irdata = bus.imem_rdata;
    @(posedge sysclk);
    g_i = e_ig;
    g_d = e_dg;
    if (s_rst) begin
      m_starve = 0; m_halt = 1'b0; m_pend = 0; m_sig_pend = 1'b0;
      m_last_i = 32'h0; m_last_d = 32'h0;
    end else begin
      if (e_iv) m_last_i = m_pend_data;
      if (e_dv) m_last_d = m_pend_data;
      if (s_ireq && !e_ig) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else m_starve = 0;
      m_sig_pend = e_dg && s_dwe && (s_daddr == SIG_A);
      if (m_sig_pend) m_sig_data = s_dwdata;
      m_pend = 0;
      if (e_ig) begin
        m_pend = 1; m_pend_data = ref_mem[widx(s_iaddr)];
      end else if (e_dg && !s_dwe) begin
        m_pend = 2; m_pend_data = mmio ? 32'h0 : ref_mem[widx(s_daddr)];
      end
      if (e_we) ref_mem[widx(s_daddr)] = s_dwdata;
      if (e_dg && s_dwe && s_daddr == HLT_A && s_dwdata == MAGIC) m_halt = 1'b1;
    end
    #1;
  endtask

  // New random requests only once the previous one was granted (or absent).
  task automatic new_reqs();
    int kind;
    if (!s_ireq || g_i) begin
      s_ireq  = ($urandom_range(0, 3) != 0);
      s_iaddr = $urandom;
    end
    if (!s_dreq || g_d) begin
      s_dreq   = ($urandom_range(0, 2) != 0);
      s_dwe    = 1'($urandom_range(0, 1));
      s_dwdata = $urandom;
      kind     = $urandom_range(0, 9);
      if (kind == 0) begin
        s_daddr = SIG_A;
      end else if (kind == 1) begin
        s_daddr = HLT_A;
        if (s_dwdata == MAGIC) s_dwdata = ~MAGIC;
      end else begin
        s_daddr = $urandom & 32'h0FF0_003F;
      end
    end
  endtask

  initial begin
    logic [9:0] pat;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    m_starve = 0; m_halt = 1'b0; m_pend = 0; m_pend_data = 32'h0;
    m_last_i = 32'h0; m_last_d = 32'h0; m_sig_pend = 1'b0; m_sig_data = 32'h0;
    g_i = 1'b0; g_d = 1'b0;
    s_rst = 1'b1; s_ireq = 1'b1; s_dreq = 1'b1; s_dwe = 1'b0;
    s_iaddr = 32'h0; s_daddr = 32'h10; s_dwdata = 32'h0;
    rst_in = 1'b1;
    bus.imem_req = 1'b1; bus.dmem_req = 1'b1;
    @(posedge sysclk);
    #1;

    // Reset held with both requests asserted
    repeat (3) begin
      run_cycle();
      check_val("rst_no_gnt", {31'h0, o_ig | o_dg}, 32'h0);
      check_val("rst_mem_en", o_men, 1'b0);
    end
    s_rst = 1'b0;
    run_cycle();
    check_val("post_rst_dgnt", o_dg, 1'b1);

    // imem only, back-to-back fetches
    s_dreq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_ireq = 1'b1; s_iaddr = 32'(4 * k);
      run_cycle();
      check_val("ionly_gnt", o_ig, 1'b1);
      check_val("ionly_addr", o_maddr, 32'(k));
    end
    s_ireq = 1'b0;
    run_cycle();
    check_val("ionly_rdata2", o_irdata, init_val(2));

    // Both requests held: imem forced through every fifth cycle
    pat = 10'b10_0001_0000;
    for (int k = 0; k < 10; k++) begin
      s_ireq = 1'b1; s_iaddr = 32'(8 * k);
      s_dreq = 1'b1; s_dwe = 1'b0; s_daddr = 32'(4 * k);
      run_cycle();
      check_val("pat_imem", o_ig, pat[k]);
      check_val("pat_dmem", o_dg, !pat[k]);
    end

    // Random traffic
    g_i = 1'b1; g_d = 1'b1;
    repeat (400) begin
      new_reqs();
      run_cycle();
    end

    // Signature write
    s_ireq = 1'b0; s_dreq = 1'b1; s_dwe = 1'b1; s_daddr = SIG_A; s_dwdata = 32'hDEAD_BEEF;
    run_cycle();
    check_val("sig_gnt", o_dg, 1'b1);
    check_val("sig_mem_en", o_men, 1'b0);
    s_dreq = 1'b0;
    run_cycle();
    check_val("sig_pulse", o_sigv, 1'b1);
    check_val("sig_word", o_sigd, 32'hDEAD_BEEF);

    // Read, then halt write: the read still returns, then everything stops
    s_dreq = 1'b1; s_dwe = 1'b0; s_daddr = 32'h40;
    run_cycle();
    s_dwe = 1'b1; s_daddr = HLT_A; s_dwdata = MAGIC;
    run_cycle();
    check_val("halt_wr_gnt", o_dg, 1'b1);
    check_val("pred_rd_rvalid", o_dval, 1'b1);
    s_dreq = 1'b0; s_ireq = 1'b1; s_iaddr = 32'h20;
    repeat (3) begin
      run_cycle();
      check_val("halt_set", o_halt, 1'b1);
      check_val("halt_no_gnt", o_ig, 1'b0);
      check_val("halt_mem_en", o_men, 1'b0);
    end
    s_rst = 1'b1;
    run_cycle();
    s_rst = 1'b0;
    run_cycle();
    check_val("halt_cleared", o_halt, 1'b0);
    check_val("post_halt_igrant", o_ig, 1'b1);

    // Reset with a read in flight
    s_ireq = 1'b0; s_dreq = 1'b1; s_dwe = 1'b0; s_daddr = 32'h40;
    run_cycle();
    check_val("inflight_gnt", o_dg, 1'b1);
    s_dreq = 1'b0; s_rst = 1'b1;
    run_cycle();
    check_val("rst_inflight_rvalid", o_dval, 1'b0);
    s_rst = 1'b0;
    run_cycle();
    check_val("rst_inflight_after", o_dval, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
